// File: rtl/stb_stretcher.sv
// stb_stretcher: per-channel strobe stretcher with retrigger/queue modes.
//
// Each channel turns a one-cycle strobe into a pulse of max(len,1) cycles.
// In retrigger mode a strobe during a pulse extends it; in queue mode it is
// counted in a small pending counter and replayed after a one-cycle gap.
//
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   asynchronous active-high reset
//   stb_in   in   [NCH] one-cycle input strobes
//   len      in   [CW]  pulse length in clk cycles (0 treated as 1)
//   retrig   in   1 = retrigger (extend), 0 = queue
//   clr_ovf  in   clears all sticky overflow flags
//   stb_out  out  [NCH] registered stretched strobes
//   busy     out  [NCH] registered, channel not IDLE
//   ovf      out  [NCH] registered sticky pending-counter overflow
//
// state  | meaning
// IDLE   | no pulse, nothing pending
// ACTIVE | stb_out high, cnt counts remaining cycles (cnt==1 is the last)
// GAP    | one low cycle between queued pulses
module stb_stretcher #(
    parameter int NCH = 4,
    parameter int CW  = 8,
    parameter int PW  = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] stb_in,
    input  logic [CW-1:0]  len,
    input  logic           retrig,
    input  logic           clr_ovf,
    output logic [NCH-1:0] stb_out,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] ovf
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    localparam logic [PW-1:0] PEND_MAX = '1;

    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [CW-1:0]  cnt_q   [NCH];
    logic [CW-1:0]  cnt_d   [NCH];
    logic [PW-1:0]  pend_q  [NCH];
    logic [PW-1:0]  pend_d  [NCH];
    logic [PW-1:0]  pend_inc[NCH];
    logic [NCH-1:0] inc_req;
    logic [NCH-1:0] inc_ok;
    logic [NCH-1:0] stb_out_q, stb_out_d;
    logic [NCH-1:0] busy_q, busy_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [CW-1:0]  len_eff;

    assign len_eff = (len == '0) ? CW'(1) : len;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            ovf_d[i]    = ovf_q[i] & ~clr_ovf;

            // Strobes that are queued rather than starting/extending a pulse.
            inc_req[i]  = stb_in[i] &&
                          ((state_q[i] == ST_ACTIVE && !retrig) || state_q[i] == ST_GAP);
            inc_ok[i]   = inc_req[i] && (pend_q[i] != PEND_MAX);
            if (inc_req[i] && (pend_q[i] == PEND_MAX)) begin
                ovf_d[i] = 1'b1;    // set beats clear
            end
            pend_inc[i] = inc_ok[i] ? pend_q[i] + PW'(1) : pend_q[i];
            pend_d[i]   = pend_inc[i];

            case (state_q[i])
                ST_IDLE: begin
                    if (stb_in[i]) begin
                        state_d[i] = ST_ACTIVE;
                        cnt_d[i]   = len_eff;
                    end
                end
                ST_ACTIVE: begin
                    if (stb_in[i] && retrig) begin
                        cnt_d[i] = len_eff;
                    end else if (cnt_q[i] <= CW'(1)) begin
                        cnt_d[i]   = '0;
                        // Pending check includes a strobe queued in this same cycle.
                        state_d[i] = (pend_inc[i] != '0) ? ST_GAP : ST_IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                    end
                end
                ST_GAP: begin
                    state_d[i] = ST_ACTIVE;
                    cnt_d[i]   = len_eff;
                    pend_d[i]  = pend_inc[i] - PW'(1);
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                    pend_d[i]  = '0;
                end
            endcase

            stb_out_d[i] = (state_d[i] == ST_ACTIVE);
            busy_d[i]    = (state_d[i] != ST_IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                pend_q[i]  <= '0;
            end
            stb_out_q <= '0;
            busy_q    <= '0;
            ovf_q     <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                pend_q[i]  <= pend_d[i];
            end
            stb_out_q <= stb_out_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign stb_out = stb_out_q;
    assign busy    = busy_q;
    assign ovf     = ovf_q;

endmodule

// File: doc/stb_stretcher.md
STB_STRETCHER -- requirements
Module: stb_stretcher

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent strobe channels (1..16).
REQ-002 SHALL have parameter CW, default 8, meaning width of the pulse-length input and per-channel down-counter.
REQ-003 SHALL have parameter PW, default 2, meaning width of the per-channel pending-strobe counter.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port stb_in  input  NCH  one-cycle input strobes, one bit per channel.
REQ-007 SHALL have port len  input  CW  output pulse length in clk cycles, shared by all channels.
REQ-008 SHALL have port retrig  input  1  mode: 1 = retrigger (extend), 0 = queue.
REQ-009 SHALL have port clr_ovf  input  1  clears all sticky overflow flags.
REQ-010 SHALL have port stb_out  output  NCH  registered stretched strobes.
REQ-011 SHALL have port busy  output  NCH  registered; 1 when the channel is not IDLE.
REQ-012 SHALL have port ovf  output  NCH  registered sticky pending-counter overflow flags.

Function
REQ-013 Each channel SHALL be an independent FSM with states IDLE, ACTIVE and GAP, a CW-bit counter cnt and a PW-bit counter pend.
REQ-014 Effective length L SHALL be max(len,1), sampled in the cycle the load occurs; len=0 behaves as len=1.
REQ-015 IDLE + stb_in=1 SHALL go to ACTIVE with cnt=L; stb_out rises the following cycle (latency 1 cycle).
REQ-016 stb_out SHALL be 1 exactly in ACTIVE; an unretriggered pulse SHALL be high exactly L consecutive cycles.
REQ-017 In ACTIVE cnt SHALL decrement each cycle; the cycle with cnt==1 is the last ACTIVE cycle.
REQ-018 ACTIVE + stb_in=1 + retrig=1 SHALL reload cnt=L, so stb_out stays high L cycles after the strobe cycle, no gap.
REQ-019 ACTIVE + stb_in=1 + retrig=0 SHALL increment pend; cnt unaffected.
REQ-020 GAP + stb_in=1 SHALL increment pend regardless of retrig.
REQ-021 At the last ACTIVE cycle: pend>0 (after this cycle's increment, if any) -> GAP; otherwise -> IDLE.
REQ-022 GAP SHALL last exactly 1 cycle with stb_out=0, then enter ACTIVE with cnt=L and pend decremented by 1.
REQ-023 Simultaneous increment and decrement of pend in one cycle SHALL leave pend unchanged.
REQ-024 pend SHALL saturate at 2^PW-1; an increment request at saturation SHALL be dropped and set ovf for that channel.
REQ-025 ovf SHALL remain set until clr_ovf=1; if set and clear coincide, set wins.
REQ-026 Last ACTIVE cycle + stb_in=1 + retrig=1 SHALL reload cnt and stay in ACTIVE (no GAP).
REQ-027 retrig changes SHALL take effect in the cycle they are applied; pend already queued is still drained via GAP/ACTIVE.
REQ-028 busy SHALL be 1 in ACTIVE and GAP and 0 in IDLE, aligned with the state register.
REQ-029 Channels SHALL NOT interact; simultaneous strobes on several channels are all honoured.

Reset
REQ-030 reset=1 SHALL asynchronously force all channels to IDLE, cnt=0, pend=0, stb_out=0, busy=0, ovf=0.
REQ-031 Reset asserted mid-pulse SHALL drop stb_out the same instant and discard queued strobes; the first rising clk edge after release samples stb_in normally.

Verification
REQ-032 len=5, retrig=0, single stb_in[0] at cycle 0 -> stb_out[0] high cycles 1..5, busy[0] high 1..5, other channels 0.
REQ-033 len=0, stb_in[1] at cycle 0 -> stb_out[1] high cycle 1 only.
REQ-034 len=4, retrig=1, strobes at cycles 0 and 2 -> stb_out high cycles 1..6 continuous.
REQ-035 len=3, retrig=0, strobes at cycles 0 and 1 -> stb_out high 1..3, low 4 (GAP), high 5..7, IDLE at 8.
REQ-036 PW=2, len=10, retrig=0, 5 strobes during one pulse -> pend saturates at 3, ovf=1, 4 pulses total separated by 1-cycle gaps; clr_ovf pulse -> ovf=0.
REQ-037 len=8, strobe at cycle 0, reset pulse at cycle 4 with a queued strobe -> stb_out=0 immediately, busy=0, no further pulse after release.
